// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter.
// Owner tags ride in the in-order tag FIFO alongside a discard flag.
package imem_arb_pkg;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_A = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   discard;
    } tag_t;

    localparam int DISCARD_CNT_W = 16;

endpackage

// File: rtl/imem_tag_fifo.sv
// In-order owner-tag FIFO for outstanding IMEM requests.
// A flush marks every fetch-owned entry for silent discard.
module imem_tag_fifo
    import imem_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  tag_t          push_tag,
    input  logic          pop,
    input  logic          flush_f,
    output tag_t          head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    tag_t          mem_q [DEPTH];
    tag_t          mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign head  = mem_q[rptr_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_f) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].owner == OWN_F) begin
                    mem_d[i].discard = 1'b1;
                end
            end
        end
        if (push) begin
            mem_d[wptr_q] = push_tag;
            if (flush_f && push_tag.owner == OWN_F) begin
                mem_d[wptr_q].discard = 1'b1;
            end
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin sharing of the IMEM port between fetch and an aux reader,
// with in-order response routing and redirect-driven fetch discard.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_fetch,
    input  logic                     f_req_valid,
    output logic                     f_req_ready,
    input  logic [ADDR_W-1:0]        f_req_addr,
    output logic                     f_resp_valid,
    input  logic                     f_resp_ready,
    output logic [DATA_W-1:0]        f_resp_inst,
    input  logic                     a_req_valid,
    output logic                     a_req_ready,
    input  logic [ADDR_W-1:0]        a_req_addr,
    output logic                     a_resp_valid,
    input  logic                     a_resp_ready,
    output logic [DATA_W-1:0]        a_resp_data,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDR_W-1:0]        mem_req_addr,
    input  logic                     mem_resp_valid,
    output logic                     mem_resp_ready,
    input  logic [DATA_W-1:0]        mem_resp_data,
    output logic                     idle,
    output logic [DISCARD_CNT_W-1:0] discard_cnt
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    owner_e                   rr_q, rr_d;
    logic                     lock_q, lock_d;
    owner_e                   lock_own_q, lock_own_d;
    logic [DISCARD_CNT_W-1:0] disc_q, disc_d;

    logic    f_cand, a_cand, both;
    logic    gnt_f, gnt_a, fire;
    logic    push, pop, drop;
    tag_t    push_tag, head;
    logic    full, empty;
    logic [CW-1:0] count;

    imem_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CW    (CW)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .flush_f  (flush_fetch),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // A stalled grant stays with its owner until the IMEM takes it.
    always_comb begin
        f_cand = f_req_valid && !flush_fetch;
        a_cand = a_req_valid;
        both   = f_cand && a_cand;
        gnt_f  = 1'b0;
        gnt_a  = 1'b0;
        if (!full) begin
            if (lock_q && lock_own_q == OWN_F && f_cand) begin
                gnt_f = 1'b1;
            end else if (lock_q && lock_own_q == OWN_A && a_cand) begin
                gnt_a = 1'b1;
            end else if (both) begin
                gnt_f = (rr_q == OWN_F);
                gnt_a = (rr_q == OWN_A);
            end else begin
                gnt_f = f_cand;
                gnt_a = a_cand;
            end
        end
    end

    always_comb begin
        mem_req_valid = gnt_f || gnt_a;
        mem_req_addr  = gnt_a ? a_req_addr : f_req_addr;
        fire          = mem_req_valid && mem_req_ready;
        f_req_ready   = gnt_f && mem_req_ready && !full;
        a_req_ready   = gnt_a && mem_req_ready && !full;
        push          = fire;
        push_tag      = '{owner: (gnt_a ? OWN_A : OWN_F), discard: 1'b0};
        rr_d          = rr_q;
        lock_d        = 1'b0;
        lock_own_d    = lock_own_q;
        if (fire && both) begin
            rr_d = gnt_f ? OWN_A : OWN_F;
        end
        if (mem_req_valid && !mem_req_ready) begin
            lock_d     = 1'b1;
            lock_own_d = gnt_a ? OWN_A : OWN_F;
        end
    end

    always_comb begin
        f_resp_inst    = mem_resp_data;
        a_resp_data    = mem_resp_data;
        f_resp_valid   = 1'b0;
        a_resp_valid   = 1'b0;
        mem_resp_ready = 1'b0;
        drop           = 1'b0;
        if (!empty) begin
            if (head.owner == OWN_A) begin
                a_resp_valid   = mem_resp_valid;
                mem_resp_ready = a_resp_ready;
            end else if (head.discard || flush_fetch) begin
                mem_resp_ready = 1'b1;
                drop           = 1'b1;
            end else begin
                f_resp_valid   = mem_resp_valid;
                mem_resp_ready = f_resp_ready;
            end
        end
        pop    = mem_resp_valid && mem_resp_ready;
        disc_d = disc_q;
        if (pop && drop && disc_q != '1) begin
            disc_d = disc_q + 1'b1;
        end
    end

    assign idle        = (count == '0);
    assign discard_cnt = disc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= OWN_F;
            lock_q     <= 1'b0;
            lock_own_q <= OWN_F;
            disc_q     <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            disc_q     <= disc_d;
        end
    end

    // A response with nothing outstanding means the IMEM broke ordering.
    resp_when_empty_a: assert property (
        @(posedge clk) disable iff (!rst_n) !(mem_resp_valid && empty)
    );

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single instruction-memory port between the fetch unit (requester F) and an auxiliary read requester (requester A: program loader / debug instruction read). It applies round-robin request arbitration and tracks the owner of every outstanding request in an in-order tag FIFO. It routes each memory response back to its owner and silently drains fetch responses invalidated by a front-end redirect. It sits between the fetch stage's IMEM request/response ports and the IMEM.

Parameters:
MAX_OUTSTANDING, 4, maximum in-flight memory requests (power of two, 2..16)
ADDR_W, 32, address width
DATA_W, 32, instruction/data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_fetch  in  1  redirect pulse: discard all in-flight fetch responses
f_req_valid  in  1  fetch request valid
f_req_ready  out  1  fetch request accepted
f_req_addr  in  ADDR_W  fetch address
f_resp_valid  out  1  fetch response valid
f_resp_ready  in  1  fetch stage accepts response
f_resp_inst  out  DATA_W  fetch response data
a_req_valid  in  1  aux request valid
a_req_ready  out  1  aux request accepted
a_req_addr  in  ADDR_W  aux address
a_resp_valid  out  1  aux response valid
a_resp_ready  in  1  aux accepts response
a_resp_data  out  DATA_W  aux response data
mem_req_valid  out  1  IMEM request valid
mem_req_ready  in  1  IMEM accepts request
mem_req_addr  out  ADDR_W  IMEM address
mem_resp_valid  in  1  IMEM response valid (in request order)
mem_resp_ready  out  1  arbiter accepts response
mem_resp_data  in  DATA_W  IMEM response data
idle  out  1  no requests outstanding
discard_cnt  out  16  saturating count of dropped fetch responses

Behaviour:
- Reset: tag FIFO empty, count=0, rr_ptr=F (fetch favoured), discard_cnt=0. Consequences: idle=1, f_resp_valid=a_resp_valid=0, mem_resp_ready=0. Reset may assert mid-transaction; all tags are lost, and the IMEM is reset on the same rst_n.
- Tag entry = {owner (F/A), discard}. The FIFO depth is MAX_OUTSTANDING. full/empty derive from the registered count; a pop in the same cycle does not free a push slot (no bypass).
- Grant (combinational): if only one requester is valid, it is granted. If both are valid, rr_ptr is granted. No grant when full.
- mem_req_valid = (F granted && !flush_fetch) || A granted. While flush_fetch=1, F is never granted and A wins if valid.
- mem_req_addr = the granted requester's address. x_req_ready = grant_x && mem_req_ready && !full.
- Request fire pushes {owner, discard=0}. The grantee must hold valid/address until ready; the arbiter does not change the grant while mem_req_valid is high and unaccepted (grant locked).
- rr_ptr toggles to the non-granted requester on every fire where both were valid. Otherwise it is unchanged.
- Response path (head entry, FIFO non-empty):
  - owner F, discard=0, flush_fetch=0: f_resp_valid=mem_resp_valid; mem_resp_ready=f_resp_ready.
  - owner F and (discard=1 or flush_fetch=1): mem_resp_ready=1, f_resp_valid=0; the fired response is dropped and discard_cnt increments (saturates at 0xFFFF).
  - owner A: a_resp_valid=mem_resp_valid; mem_resp_ready=a_resp_ready. A responses are never discarded.
  - FIFO empty: mem_resp_ready=0. A response arriving while empty is a protocol error; assert in simulation.
- Response data is passed combinationally to both data outputs; zero latency through the arbiter.
- flush_fetch sets discard on every FIFO entry with owner F, including any entry pushed in the same cycle (cannot occur, since F is blocked). Entries popped in the flush cycle follow the drop rule above.
- Push and pop in the same cycle: count unchanged, pointers both advance, and wrap modulo MAX_OUTSTANDING.
- idle = (count==0).

Decomposition:
- imem_arb_pkg: owner_e {OWN_F, OWN_A}; tag_t struct {owner_e owner; logic discard}; localparam DISCARD_CNT_W=16.
- Sub-module imem_tag_fifo: push/pop/count, per-entry discard-set on flush by owner. The top level holds arbitration, routing, and counters.

Test Plan:
- Only F valid, addresses 0x0,0x4,0x8, mem_req_ready=1, IMEM 2-cycle latency -> three mem requests in consecutive cycles; responses routed to F in order; a_resp_valid stays 0; idle returns to 1.
- F and A both valid continuously -> grants alternate F,A,F,A starting with F after reset; each response is routed to the matching owner.
- MAX_OUTSTANDING=4, IMEM responses held off -> 4 requests fire, then f_req_ready=a_req_ready=0 until the first response pops; the 5th fires the cycle after the pop.
- 3 F requests in flight, pulse flush_fetch, then F issues 0x100 -> first 3 responses are consumed with f_resp_valid=0 and discard_cnt=3; the 0x100 response is delivered.
- mem_req_ready=0 with F granted, A asserts next cycle -> grant stays F until fire; addr is stable.
- Assert rst_n=0 with 2 requests outstanding -> idle=1, discard_cnt=0, and all resp valids=0 immediately (async).
